// File: rtl/seg_pkg.sv
// Shared constants, FSM encoding, request payload and double-dabble helper
// for the HEX display encoder.
package seg_pkg;

  localparam int unsigned SEG_W  = 8;
  localparam int unsigned NUM_W  = 7;
  localparam int unsigned MON_W  = 4;
  localparam int unsigned DAY_W  = 5;
  localparam int unsigned BCD_W  = 8;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned SHIFTS = 7;

  localparam int unsigned NUM_MAX   = 99;
  localparam int unsigned MONTH_MAX = 12;
  localparam int unsigned DAY_MAX   = 31;

  localparam logic [SEG_W-1:0] SEG_DIGIT [0:9] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
  };
  localparam logic [SEG_W-1:0] SEG_BLANK = 8'hFF;
  localparam logic [SEG_W-1:0] SEG_DASH  = 8'hBF;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CONV_NUM = 3'd1,
    ST_CONV_MON = 3'd2,
    ST_CONV_DAY = 3'd3,
    ST_UPDATE   = 3'd4
  } state_e;

  typedef struct packed {
    logic [NUM_W-1:0] num;
    logic [MON_W-1:0] month;
    logic [DAY_W-1:0] day;
  } date_req_t;

  // Add 3 to every BCD nibble that is 5 or more, ahead of the next shift.
  function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] a);
    logic [BCD_W-1:0] r;
    r = a;
    if (r[3:0] >= 4'd5) r[3:0] = r[3:0] + 4'd3;
    if (r[7:4] >= 4'd5) r[7:4] = r[7:4] + 4'd3;
    return r;
  endfunction

endpackage

// File: rtl/date_seg_encoder_if.sv
// Request/result bundle between the date logic and the HEX encoder.
interface date_seg_encoder_if;
  import seg_pkg::*;

  logic             load;
  date_req_t        req;
  logic             busy;
  logic             done;
  logic             err;
  logic [SEG_W-1:0] hex0, hex1, hex2, hex3, hex4, hex5;

  modport master (output load, req,
                  input  busy, done, err, hex0, hex1, hex2, hex3, hex4, hex5);
  modport slave  (input  load, req,
                  output busy, done, err, hex0, hex1, hex2, hex3, hex4, hex5);
endinterface

// File: rtl/bcd_to_seg.sv
// One BCD digit to an active-low 7-segment code; non-decimal values blank.
module bcd_to_seg
  import seg_pkg::*;
(
  input  logic [3:0]       bcd,
  output logic [SEG_W-1:0] seg_c
);

  always_comb begin
    seg_c = SEG_BLANK;
    case (bcd)
      4'd0: seg_c = SEG_DIGIT[0];
      4'd1: seg_c = SEG_DIGIT[1];
      4'd2: seg_c = SEG_DIGIT[2];
      4'd3: seg_c = SEG_DIGIT[3];
      4'd4: seg_c = SEG_DIGIT[4];
      4'd5: seg_c = SEG_DIGIT[5];
      4'd6: seg_c = SEG_DIGIT[6];
      4'd7: seg_c = SEG_DIGIT[7];
      4'd8: seg_c = SEG_DIGIT[8];
      4'd9: seg_c = SEG_DIGIT[9];
      default: seg_c = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/date_seg_encoder.sv
// Converts num/month/day to six HEX codes using one shared sequential
// double-dabble engine, one field after another, with a fixed 22-cycle latency.
module date_seg_encoder
  import seg_pkg::*;
#(
  parameter bit BLANK_LEAD = 1'b1,
  parameter bit SEG_INVERT = 1'b0
) (
  input logic               clk,
  input logic               reset,
  date_seg_encoder_if.slave bus
);

  localparam logic [SEG_W-1:0] INV_MASK = {SEG_W{SEG_INVERT}};
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SHIFTS - 1);

  state_e            state_q, state_n;
  logic [CNT_W-1:0]  cnt_q, cnt_n;
  logic              last_shift;

  date_req_t         req_q;
  logic [NUM_W-1:0]  sh_q;
  logic [BCD_W-1:0]  acc_q, acc_adj, acc_sh;
  logic [BCD_W-1:0]  bcd_num_q, bcd_mon_q, bcd_day_q;

  logic [SEG_W-1:0]  seg_nt, seg_nu, seg_mt, seg_mu, seg_dt, seg_du;
  logic [SEG_W-1:0]  h5_n, h4_n, h3_n, h2_n, h1_n, h0_n;
  logic              num_bad, mon_bad, day_bad;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
    end
  end

  always_comb begin
    state_n    = state_q;
    cnt_n      = cnt_q;
    last_shift = (cnt_q == LAST_CNT);
    case (state_q)
      ST_IDLE: begin
        if (bus.load) begin
          state_n = ST_CONV_NUM;
          cnt_n   = '0;
        end
      end
      ST_CONV_NUM, ST_CONV_MON, ST_CONV_DAY: begin
        if (last_shift) begin
          cnt_n = '0;
          case (state_q)
            ST_CONV_NUM: state_n = ST_CONV_MON;
            ST_CONV_MON: state_n = ST_CONV_DAY;
            default:     state_n = ST_UPDATE;
          endcase
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      ST_UPDATE: state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase
  end

  // One double-dabble step: adjust, then shift the next source bit in.
  assign acc_adj = dd_adjust(acc_q);
  assign acc_sh  = {acc_adj[BCD_W-2:0], sh_q[NUM_W-1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      req_q     <= '0;
      sh_q      <= '0;
      acc_q     <= '0;
      bcd_num_q <= '0;
      bcd_mon_q <= '0;
      bcd_day_q <= '0;
      bus.busy  <= 1'b0;
      bus.done  <= 1'b0;
      bus.err   <= 1'b0;
      bus.hex0  <= SEG_BLANK ^ INV_MASK;
      bus.hex1  <= SEG_BLANK ^ INV_MASK;
      bus.hex2  <= SEG_BLANK ^ INV_MASK;
      bus.hex3  <= SEG_BLANK ^ INV_MASK;
      bus.hex4  <= SEG_BLANK ^ INV_MASK;
      bus.hex5  <= SEG_BLANK ^ INV_MASK;
    end else begin
      bus.done <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.load) begin
            req_q    <= bus.req;
            sh_q     <= bus.req.num;
            acc_q    <= '0;
            bus.busy <= 1'b1;
          end
        end
        ST_CONV_NUM, ST_CONV_MON, ST_CONV_DAY: begin
          sh_q  <= {sh_q[NUM_W-2:0], 1'b0};
          acc_q <= acc_sh;
          if (last_shift) begin
            acc_q <= '0;
            case (state_q)
              ST_CONV_NUM: begin
                bcd_num_q <= acc_sh;
                sh_q      <= NUM_W'(req_q.month);
              end
              ST_CONV_MON: begin
                bcd_mon_q <= acc_sh;
                sh_q      <= NUM_W'(req_q.day);
              end
              default: bcd_day_q <= acc_sh;
            endcase
          end
        end
        ST_UPDATE: begin
          bus.hex5 <= h5_n ^ INV_MASK;
          bus.hex4 <= h4_n ^ INV_MASK;
          bus.hex3 <= h3_n ^ INV_MASK;
          bus.hex2 <= h2_n ^ INV_MASK;
          bus.hex1 <= h1_n ^ INV_MASK;
          bus.hex0 <= h0_n ^ INV_MASK;
          bus.err  <= num_bad | mon_bad | day_bad;
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  bcd_to_seg u_num_t (.bcd(bcd_num_q[7:4]), .seg_c(seg_nt));
  bcd_to_seg u_num_u (.bcd(bcd_num_q[3:0]), .seg_c(seg_nu));
  bcd_to_seg u_mon_t (.bcd(bcd_mon_q[7:4]), .seg_c(seg_mt));
  bcd_to_seg u_mon_u (.bcd(bcd_mon_q[3:0]), .seg_c(seg_mu));
  bcd_to_seg u_day_t (.bcd(bcd_day_q[7:4]), .seg_c(seg_dt));
  bcd_to_seg u_day_u (.bcd(bcd_day_q[3:0]), .seg_c(seg_du));

  assign num_bad = (req_q.num > NUM_W'(NUM_MAX));
  assign mon_bad = (req_q.month == '0) || (req_q.month > MON_W'(MONTH_MAX));
  assign day_bad = (req_q.day == '0) || ({1'b0, req_q.day} > (DAY_W + 1)'(DAY_MAX));

  // Range dashes override digits; leading blanks apply only to valid fields.
  always_comb begin
    h5_n = seg_nt;
    h4_n = seg_nu;
    h3_n = seg_mt;
    h2_n = seg_mu;
    h1_n = seg_dt;
    h0_n = seg_du;
    if (num_bad) begin
      h5_n = SEG_DASH;
      h4_n = SEG_DASH;
    end else if (BLANK_LEAD && (req_q.num < NUM_W'(10))) begin
      h5_n = SEG_BLANK;
    end
    if (mon_bad) begin
      h3_n = SEG_DASH;
      h2_n = SEG_DASH;
    end else if (req_q.month < MON_W'(10)) begin
      h3_n = SEG_BLANK;
    end
    if (day_bad) begin
      h1_n = SEG_DASH;
      h0_n = SEG_DASH;
    end
  end

endmodule
